// File: rtl/pedestrian_request_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pedestrian_request_conditioner_pkg
// Brief    : Shared state encoding, defaults and counter helpers for the
//            pedestrian request conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package pedestrian_request_conditioner_pkg;

    localparam int unsigned      C_CNT_W        = 8;
    localparam logic [C_CNT_W-1:0] C_DEF_DEBOUNCE = 8'd3;
    localparam logic [C_CNT_W-1:0] C_DEF_COOLDOWN = 8'd4;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COOLDOWN = 2'd2
    } req_state_e;

    function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pedestrian_request_conditioner_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Brief    : Two-flop synchroniser followed by a consecutive-cycle debounce
//            filter for the raw pedestrian button.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_filter
    import pedestrian_request_conditioner_pkg::*;
#(
    parameter logic [C_CNT_W-1:0] DEBOUNCE = C_DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic               s1_q;
    logic               s2_q;
    logic               db_q;
    logic [C_CNT_W-1:0] dcnt_q;

    // The filtered level only flips after s2 has disagreed with it for
    // DEBOUNCE consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            dcnt_q <= '0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            if (s2_q == db_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == DEBOUNCE - 8'd1) begin
                db_q   <= s2_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 8'd1;
            end
        end
    end

    assign dout = db_q;

endmodule
`default_nettype wire

// File: rtl/pedestrian_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pedestrian_request_conditioner
// Brief    : Turns the bouncing pedestrian button into a held request level
//            for the light controller, with post-acknowledge cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module pedestrian_request_conditioner
    import pedestrian_request_conditioner_pkg::*;
#(
    parameter logic [C_CNT_W-1:0] DEBOUNCE = C_DEF_DEBOUNCE,
    parameter logic [C_CNT_W-1:0] COOLDOWN = C_DEF_COOLDOWN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bt_raw,
    input  logic               ack,
    output logic               bt,
    output logic               busy,
    output logic [C_CNT_W-1:0] press_cnt
);

    logic               db;
    logic               db_d_q;
    logic               rise;
    req_state_e         state_q;
    req_state_e         state_d;
    logic [C_CNT_W-1:0] ccnt_q;
    logic [C_CNT_W-1:0] ccnt_d;
    logic [C_CNT_W-1:0] pcnt_q;
    logic [C_CNT_W-1:0] pcnt_d;

    debounce_filter #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (bt_raw),
        .dout (db)
    );

    assign rise = db & ~db_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_d_q  <= 1'b0;
            state_q <= ST_IDLE;
            ccnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            db_d_q  <= db;
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // A rise outside IDLE is never counted: it is merged while PENDING and
    // dropped while COOLDOWN, so a held button needs a fresh edge afterwards.
    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PENDING;
                    pcnt_d  = sat_inc(pcnt_q);
                end
            end
            ST_PENDING: begin
                if (ack) begin
                    if (COOLDOWN == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COOLDOWN;
                        ccnt_d  = COOLDOWN - 8'd1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (ccnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ccnt_d = ccnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bt        = (state_q == ST_PENDING);
    assign busy      = (state_q == ST_COOLDOWN);
    assign press_cnt = pcnt_q;

endmodule
`default_nettype wire
